uart_stream_scheduler: RTL and testbench

UART_STREAM_SCHEDULER -- requirements
Module: uart_stream_scheduler

---
 rtl/uart_stream_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_uart_stream_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_scheduler.sv
// uart_stream_scheduler
// Shares one UART transmitter between NUM_SRC sample sources. Each source owns
// a single-entry holding register (newest sample wins). A round-robin arbiter
// hands one pending sample at a time to the transmitter. After each launch the
// block waits for the busy handshake, or gives up after ACK_TIMEOUT cycles.
module uart_stream_scheduler #(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic [NUM_SRC-1:0]            src_mask_in,
    input  logic [NUM_SRC-1:0]            src_valid_in,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_in,
    input  logic                          tx_busy_in,
    output logic [DATA_WIDTH-1:0]         tx_data_out,
    output logic [$clog2(NUM_SRC)-1:0]    tx_src_out,
    output logic                          tx_trigger_out,
    output logic [NUM_SRC-1:0]            pending_out,
    output logic [15:0]                   drop_count_out,
    output logic                          timeout_out
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_ack_cnt;
    logic [DATA_WIDTH-1:0] r_hold [NUM_SRC];
    logic [NUM_SRC-1:0]    r_pending;
    logic [SRC_W-1:0]      r_last_grant;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [SRC_W-1:0]      r_tx_src;
    logic                  r_trigger;
    logic [15:0]           r_drop_cnt;
    logic                  r_timeout;

    logic [NUM_SRC-1:0]    w_req;
    logic                  w_any_req;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic                  w_grant;
    logic                  w_timeout_hit;
    logic [NUM_SRC-1:0]    w_pending_nxt;
    logic [SRC_W:0]        w_drop_num;

    // Saturating add for the overwrite counter; it sticks at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] base,
                                              input logic [SRC_W:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // A source only competes while it is both holding a sample and enabled.
    assign w_req = r_pending & src_mask_in;

    // Round-robin search starting just after the most recent grant.
    always_comb begin
        int idx;
        idx       = 0;
        w_any_req = 1'b0;
        w_gnt_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!w_any_req && w_req[SRC_W'(idx)]) begin
                w_any_req = 1'b1;
                w_gnt_idx = SRC_W'(idx);
            end
        end
    end

    // Next-state logic: launch from IDLE, then track the busy handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_in && !tx_busy_in && w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy_in) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_in) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pending bookkeeping; a valid on the granted source re-arms it without a drop.
    always_comb begin
        w_pending_nxt = r_pending;
        w_drop_num    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!src_mask_in[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else if (src_valid_in[i]) begin
                w_pending_nxt[i] = 1'b1;
                if (r_pending[i] && !(w_grant && (w_gnt_idx == SRC_W'(i)))) begin
                    w_drop_num = w_drop_num + (SRC_W + 1)'(1);
                end
            end else if (w_grant && (w_gnt_idx == SRC_W'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
    end

    // State register and acknowledge-wait counter.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= ST_IDLE;
            r_ack_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WAIT_ACK) begin
                r_ack_cnt <= r_ack_cnt + CNT_W'(1);
            end else begin
                r_ack_cnt <= '0;
            end
        end
    end

    // Holding registers: data only, validity is tracked by r_pending.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_mask_in[i] && src_valid_in[i]) begin
                r_hold[i] <= src_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pending flags; reset discards every held sample.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Launch registers, grant history, drop counter and sticky timeout flag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_tx_data    <= '0;
            r_tx_src     <= '0;
            r_trigger    <= 1'b0;
            r_last_grant <= SRC_W'(NUM_SRC - 1);
            r_drop_cnt   <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_trigger  <= w_grant;
            r_drop_cnt <= sat_add16(r_drop_cnt, w_drop_num);
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_grant) begin
                r_tx_data    <= r_hold[w_gnt_idx];
                r_tx_src     <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    assign tx_data_out    = r_tx_data;
    assign tx_src_out     = r_tx_src;
    assign tx_trigger_out = r_trigger;
    assign pending_out    = r_pending;
    assign drop_count_out = r_drop_cnt;
    assign timeout_out    = r_timeout;

endmodule

// File: tb/tb_uart_stream_scheduler.sv
// Bench for uart_stream_scheduler: directed scenarios plus a randomized run,
// all checked against a behavioural model and a transmission scoreboard.
module tb_uart_stream_scheduler;

    localparam int ACK = 8;

    typedef struct {
        int          src;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int          src;
        logic [15:0] data;
        int          cyc;
    } trig_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [3:0]  mask = 4'hF;
    logic [3:0]  valid = 4'h0;
    logic [63:0] data = '0;
    logic        tx_busy = 1'b0;
    logic [15:0] tx_data;
    logic [1:0]  tx_src;
    logic        tx_trig;
    logic [3:0]  pending;
    logic [15:0] drops;
    logic        timeout;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // transmitter model controls
    bit reply_en = 1'b1;
    int busy_len = 20;
    int busy_left = 0;
    bit start_pend = 1'b0;

    // monitor records
    trig_t trig_log[$];
    int    trig_cnt = 0;
    bit    to_seen = 1'b0;
    int    to_cyc = 0;

    // reference model state
    exp_t        exp_q[$];
    logic [15:0] m_hold[4];
    bit          m_pend[4];
    int          m_last, m_phase, m_age, m_drops, m_txs;
    bit          m_trig, m_timeout;
    logic [15:0] m_txd;

    uart_stream_scheduler #(.NUM_SRC(4), .DATA_WIDTH(16), .ACK_TIMEOUT(ACK)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .enable_in     (en),
        .src_mask_in   (mask),
        .src_valid_in  (valid),
        .src_data_in   (data),
        .tx_busy_in    (tx_busy),
        .tx_data_out   (tx_data),
        .tx_src_out    (tx_src),
        .tx_trigger_out(tx_trig),
        .pending_out   (pending),
        .drop_count_out(drops),
        .timeout_out   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [3:0] v, input logic [63:0] d, output int t);
        t = cyc;
        valid = v;
        data = d;
        tick(1);
        valid = '0;
    endtask

    task automatic do_reset();
        valid = '0;
        reply_en = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        reply_en = 1'b1;
        to_seen = 1'b0;
        tick(1);
    endtask

    // Transmitter: raises busy the cycle after a trigger and holds it busy_len cycles.
    always @(negedge clk) begin
        if (!reply_en) begin
            busy_left = 0;
            start_pend = 1'b0;
        end
        if (start_pend) begin
            busy_left = busy_len;
            start_pend = 1'b0;
        end
        tx_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (tx_trig && reply_en) start_pend = 1'b1;
    end

    // Behavioural reference: one slot per source, round-robin from last grant,
    // launch only when idle; the transfer waits for busy then for its release.
    always @(posedge clk) begin
        int g;
        logic [15:0] gd;
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            m_last = 3; m_phase = 0; m_age = 0; m_trig = 1'b0; m_timeout = 1'b0;
            m_drops = 0; m_txd = '0; m_txs = 0;
            exp_q.delete();
        end else begin
            g = -1;
            gd = '0;
            if (m_phase == 0 && en && !tx_busy) begin
                for (int k = 1; k <= 4; k++) begin
                    int s;
                    s = (m_last + k) % 4;
                    if (g < 0 && m_pend[s] && mask[s]) g = s;
                end
            end
            if (g >= 0) gd = m_hold[g];
            if (m_phase == 1) begin
                m_age++;
                if (tx_busy) m_phase = 2;
                else if (m_age == ACK) begin
                    m_timeout = 1'b1;
                    m_phase = 0;
                end
            end else if (m_phase == 2) begin
                if (!tx_busy) m_phase = 0;
            end
            if (g >= 0) begin
                m_phase = 1; m_age = 0; m_last = g; m_txd = gd; m_txs = g;
                e.src = g; e.data = gd;
                exp_q.push_back(e);
            end
            m_trig = (g >= 0);
            for (int i = 0; i < 4; i++) begin
                if (!mask[i]) m_pend[i] = 1'b0;
                else if (valid[i]) begin
                    if (m_pend[i] && g != i) m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
                    m_hold[i] = data[i*16 +: 16];
                    m_pend[i] = 1'b1;
                end else if (g == i) m_pend[i] = 1'b0;
            end
        end
    end

    // Monitor: compare visible state every cycle and pop the scoreboard on each trigger.
    always @(negedge clk) begin
        exp_t e;
        trig_t tr;
        if (cyc >= 1) begin
            check("mon_trigger", tx_trig, m_trig);
            check("mon_pending", pending, {m_pend[3], m_pend[2], m_pend[1], m_pend[0]});
            check("mon_drops", drops, m_drops);
            check("mon_timeout", timeout, m_timeout);
            check("mon_txdata", tx_data, m_txd);
            check("mon_txsrc", tx_src, m_txs);
            if (tx_trig) begin
                tr.src = tx_src; tr.data = tx_data; tr.cyc = cyc;
                trig_log.push_back(tr);
                trig_cnt++;
                check("sb_expected_present", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_src", tx_src, e.src);
                    check("sb_data", tx_data, e.data);
                end
            end
            if (timeout && !to_seen) begin
                to_seen = 1'b1;
                to_cyc = cyc;
            end
        end
    end

    initial begin
        int t, n0, n1;
        do_reset();
        check("rst_txdata", tx_data, 0);
        check("rst_txsrc", tx_src, 0);
        check("rst_trigger", tx_trig, 0);
        check("rst_pending", pending, 0);
        check("rst_drops", drops, 0);
        check("rst_timeout", timeout, 0);

        // single source latency and payload
        n0 = trig_cnt;
        pulse(4'b0001, {48'h0, 16'hA5A5}, t);
        tick(28);
        check("s1_count", trig_cnt - n0, 1);
        if (trig_log.size() > n0) begin
            check("s1_latency", trig_log[n0].cyc - t, 2);
            check("s1_data", trig_log[n0].data, 16'hA5A5);
            check("s1_src", trig_log[n0].src, 0);
        end

        // round-robin from reset, then wrap after last_grant=3
        do_reset();
        n0 = trig_cnt;
        pulse(4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, t);
        tick(100);
        check("rr_count", trig_cnt - n0, 4);
        if (trig_log.size() >= n0 + 4) begin
            for (int k = 0; k < 4; k++) begin
                check("rr_order", trig_log[n0+k].src, k);
                check("rr_data", trig_log[n0+k].data, (k + 1) * 'h1111);
            end
            check("rr_spacing", trig_log[n0+1].cyc - trig_log[n0].cyc, 23);
        end
        n1 = trig_cnt;
        pulse(4'b0101, {16'h0, 16'hCCCC, 16'h0, 16'hAAAA}, t);
        tick(50);
        check("rr2_count", trig_cnt - n1, 2);
        if (trig_log.size() >= n1 + 2) begin
            check("rr2_first", trig_log[n1].src, 0);
            check("rr2_second", trig_log[n1+1].src, 2);
            check("rr2_data", trig_log[n1+1].data, 16'hCCCC);
        end

        // overwrite while the transmitter is busy
        do_reset();
        pulse(4'b0001, {48'h0, 16'h00F0}, t);
        tick(4);
        pulse(4'b0010, {32'h0, 16'h0001, 16'h0}, t);
        pulse(4'b0010, {32'h0, 16'h0002, 16'h0}, t);
        pulse(4'b0010, {32'h0, 16'h0003, 16'h0}, t);
        tick(1);
        check("ovw_drops", drops, 2);
        n0 = trig_cnt;
        tick(30);
        check("ovw_count", trig_cnt - n0, 1);
        if (trig_log.size() > n0) begin
            check("ovw_data", trig_log[n0].data, 16'h0003);
            check("ovw_src", trig_log[n0].src, 1);
        end

        // acknowledge timeout, then the next pending source goes out
        do_reset();
        reply_en = 1'b0;
        n0 = trig_cnt;
        pulse(4'b1010, {16'h3333, 16'h0, 16'h1111, 16'h0}, t);
        tick(30);
        check("to_count", trig_cnt - n0, 2);
        check("to_seen", to_seen, 1);
        check("to_flag", timeout, 1);
        if (trig_log.size() >= n0 + 2) begin
            check("to_first_src", trig_log[n0].src, 1);
            check("to_delay", to_cyc - trig_log[n0].cyc, ACK);
            check("to_next_src", trig_log[n0+1].src, 3);
            check("to_next_delay", trig_log[n0+1].cyc - to_cyc, 1);
        end

        // mask and enable
        do_reset();
        en = 1'b0;
        n0 = trig_cnt;
        pulse(4'b0100, {16'h0, 16'h5555, 32'h0}, t);
        tick(1);
        check("mask_pending_set", pending, 4'b0100);
        mask = 4'b1011;
        tick(1);
        check("mask_clear", pending[2], 0);
        mask = 4'hF;
        pulse(4'b0011, {32'h0, 16'h0B0B, 16'h0A0A}, t);
        tick(10);
        check("en_low_no_trig", trig_cnt - n0, 0);
        check("en_low_pending", pending, 4'b0011);
        en = 1'b1;
        tick(60);
        check("en_high_count", trig_cnt - n0, 2);
        if (trig_log.size() >= n0 + 2) begin
            check("en_first_src", trig_log[n0].src, 0);
            check("en_first_data", trig_log[n0].data, 16'h0A0A);
            check("en_second_src", trig_log[n0+1].src, 1);
        end
        n1 = trig_cnt;
        pulse(4'b1001, {16'h0D0D, 32'h0, 16'h0E0E}, t);
        tick(4);
        en = 1'b0;
        tick(40);
        check("en_fall_count", trig_cnt - n1, 1);
        check("en_fall_pending", pending, 4'b0001);
        en = 1'b1;
        tick(30);
        check("en_rise_count", trig_cnt - n1, 2);
        if (trig_log.size() >= n1 + 2) check("en_rise_src", trig_log[n1+1].src, 0);

        // reset in the middle of a transfer
        do_reset();
        pulse(4'b0001, {48'h0, 16'h1234}, t);
        tick(8);
        pulse(4'b0100, {16'h0, 16'h5678, 32'h0}, t);
        check("mid_pending_before", pending, 4'b0100);
        rst_n = 1'b0;
        reply_en = 1'b0;
        tick(1);
        check("mid_txdata", tx_data, 0);
        check("mid_txsrc", tx_src, 0);
        check("mid_trigger", tx_trig, 0);
        check("mid_pending", pending, 0);
        check("mid_drops", drops, 0);
        check("mid_timeout", timeout, 0);
        rst_n = 1'b1;
        reply_en = 1'b1;
        to_seen = 1'b0;
        n1 = trig_cnt;
        tick(20);
        check("mid_no_trig", trig_cnt - n1, 0);
        pulse(4'b0010, {32'h0, 16'h9ABC, 16'h0}, t);
        tick(5);
        check("mid_new_count", trig_cnt - n1, 1);
        if (trig_log.size() > n1) check("mid_new_data", trig_log[n1].data, 16'h9ABC);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            valid = 4'($urandom) & 4'($urandom);
            data = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            if ($urandom_range(0, 31) == 0) en = ~en;
            if ($urandom_range(0, 63) == 0) reply_en = ~reply_en;
            busy_len = $urandom_range(1, 6);
            rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        valid = '0;
        rst_n = 1'b1;
        en = 1'b1;
        mask = 4'hF;
        reply_en = 1'b1;
        tick(200);
        check("drain_scoreboard", exp_q.size(), 0);
        check("drain_pending", pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
